// File: rtl/ksa_alu_pipe_if.sv
// rtl/ksa_alu_pipe_if.sv - issue/writeback handshake bundle for ksa_alu_pipe
// KSA_ALU_SAT_EN adds the sticky o_sat status line.
`timescale 1ns/1ps

interface ksa_alu_pipe_if;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_s;
  logic [3:0]  o_flags;
  logic        o_cf;
  logic        o_err;
`ifdef KSA_ALU_SAT_EN
  logic        o_sat;

  modport master (
    output i_valid, i_op, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_s, o_flags, o_cf, o_err, o_sat
  );
  modport slave (
    input  i_valid, i_op, i_a, i_b, i_ready,
    output o_ready, o_valid, o_s, o_flags, o_cf, o_err, o_sat
  );
`else
  modport master (
    output i_valid, i_op, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_s, o_flags, o_cf, o_err
  );
  modport slave (
    input  i_valid, i_op, i_a, i_b, i_ready,
    output o_ready, o_valid, o_s, o_flags, o_cf, o_err
  );
`endif
endinterface

// File: rtl/ksa_alu_pipe.sv
// rtl/ksa_alu_pipe.sv - two-stage add/sub unit around a 32-bit Kogge-Stone adder
// KSA_ALU_SAT_EN enables ADDS/SUBS (ops 110/111) and the sticky o_sat flag.
`timescale 1ns/1ps

module ksa_top (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);
  logic [31:0] gg, pp, gn, pn, p0;
  logic [32:0] c;

  // Five prefix levels give group generate/propagate over bits [i:0].
  always_comb begin
    gg = a & b;
    pp = a ^ b;
    p0 = pp;
    for (int l = 0; l < 5; l++) begin
      gn = gg;
      pn = pp;
      for (int i = (1 << l); i < 32; i++) begin
        gn[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
        pn[i] = pp[i] & pp[i - (1 << l)];
      end
      gg = gn;
      pp = pn;
    end
    c[0] = cin;
    for (int i = 0; i < 32; i++) begin
      c[i+1] = gg[i] | (pp[i] & cin);
    end
    s    = p0 ^ c[31:0];
    cout = c[32];
  end
endmodule

module ksa_alu_pipe #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  ksa_alu_pipe_if.slave bus
);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SBC = 3'b011;
  localparam logic [2:0] OP_CMP = 3'b100;
  localparam logic [2:0] OP_CLC = 3'b101;
`ifdef KSA_ALU_SAT_EN
  localparam logic [2:0] OP_ADDS = 3'b110;
  localparam logic [2:0] OP_SUBS = 3'b111;
`endif

  generate
    if (W != 32) begin : g_bad_width
      $error("ksa_alu_pipe: W must be 32 to match the adder core");
    end
  endgenerate

  logic         s1_valid;
  logic [2:0]   s1_op;
  logic [W-1:0] s1_a, s1_b;
  logic         s2_valid;
  logic [W-1:0] s2_s;
  logic [3:0]   s2_flags;
  logic         s2_err;
  logic         cf;

  logic         accept, s2_adv;
  logic [W-1:0] bx, sum, res_s;
  logic         c0, cout, v;
  logic [3:0]   res_flags;
  logic         res_err, cf_we, cf_next;
`ifdef KSA_ALU_SAT_EN
  logic         sat, sat_set, sat_clr;
  logic [W-1:0] clamp;
`endif

  assign s2_adv      = s1_valid && (!s2_valid || bus.i_ready);
  assign bus.o_ready = !s1_valid || s2_adv;
  assign accept      = bus.i_valid && bus.o_ready;

  // CF is sampled here only after the previous op has left stage 1, so chains need no bypass.
  always_comb begin
    bx = s1_b;
    c0 = 1'b0;
    case (s1_op)
      OP_ADC:         c0 = cf;
      OP_SUB, OP_CMP: begin bx = ~s1_b; c0 = 1'b1; end
      OP_SBC:         begin bx = ~s1_b; c0 = cf; end
`ifdef KSA_ALU_SAT_EN
      OP_SUBS:        begin bx = ~s1_b; c0 = 1'b1; end
`endif
      default: ;
    endcase
  end

  ksa_top u_adder (
    .a    (s1_a),
    .b    (bx),
    .cin  (c0),
    .s    (sum),
    .cout (cout)
  );

  assign v = (s1_a[W-1] == bx[W-1]) && (sum[W-1] != s1_a[W-1]);

  always_comb begin
    res_s     = '0;
    res_flags = 4'b0000;
    res_err   = 1'b0;
    cf_we     = 1'b0;
    cf_next   = cf;
`ifdef KSA_ALU_SAT_EN
    sat_set   = 1'b0;
    sat_clr   = 1'b0;
    clamp     = s1_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    case (s1_op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        res_s     = sum;
        res_flags = {sum[W-1], ~|sum, cout, v};
        cf_we     = 1'b1;
        cf_next   = cout;
      end
      OP_CMP: begin
        res_flags = {sum[W-1], ~|sum, cout, v};
        cf_we     = 1'b1;
        cf_next   = cout;
      end
      OP_CLC: begin
        cf_we     = 1'b1;
        cf_next   = 1'b0;
`ifdef KSA_ALU_SAT_EN
        sat_clr   = 1'b1;
`endif
      end
`ifdef KSA_ALU_SAT_EN
      OP_ADDS, OP_SUBS: begin
        res_s     = v ? clamp : sum;
        res_flags = {res_s[W-1], ~|res_s, cout, v};
        cf_we     = 1'b1;
        cf_next   = cout;
        sat_set   = v;
      end
`endif
      default: res_err = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= 3'b000;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op    <= bus.i_op;
      s1_a     <= bus.i_a;
      s1_b     <= bus.i_b;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      s2_s     <= '0;
      s2_flags <= 4'b0000;
      s2_err   <= 1'b0;
      cf       <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= 1'b1;
      s2_s     <= res_s;
      s2_flags <= res_flags;
      s2_err   <= res_err;
      if (cf_we) cf <= cf_next;
    end else if (bus.i_ready) begin
      s2_valid <= 1'b0;
    end
  end

`ifdef KSA_ALU_SAT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sat <= 1'b0;
    end else if (s2_adv) begin
      if (sat_clr)      sat <= 1'b0;
      else if (sat_set) sat <= 1'b1;
    end
  end
  assign bus.o_sat = sat;
`endif

  assign bus.o_valid = s2_valid;
  assign bus.o_s     = s2_s;
  assign bus.o_flags = s2_flags;
  assign bus.o_err   = s2_err;
  assign bus.o_cf    = cf;
endmodule

// File: tb/tb_ksa_alu_pipe.sv
// tb/tb_ksa_alu_pipe.sv - directed self-checking bench for ksa_alu_pipe
// Define KSA_ALU_SAT_EN to exercise ADDS/SUBS instead of the illegal-op path.
`timescale 1ns/1ps

module tb_ksa_alu_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ksa_alu_pipe_if bus();
  ksa_alu_pipe #(.W(32)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  int checks = 0;
  int passed = 0;
  logic [36:0] rq[$];

  // Record each consumed result; inputs only change on negedge, so +2 is stable.
  always @(negedge clk) begin
    #2;
    if (rst_n && bus.o_valid && bus.i_ready) rq.push_back({bus.o_err, bus.o_flags, bus.o_s});
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time expired");
    $fatal(1);
  end

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit done;
    done = 1'b0;
    bus.i_valid = 1'b1; bus.i_op = op; bus.i_a = a; bus.i_b = b;
    for (int n = 0; n < 40 && !done; n++) begin
      #1;
      done = bus.o_ready;
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      $display("FAIL send_timeout: o_ready=0 want 1");
    end
  endtask

  task automatic get_result(output logic [31:0] s, output logic [3:0] f, output logic e, output bit ok);
    ok = 1'b0; s = '0; f = '0; e = 1'b0;
    for (int n = 0; n < 20 && rq.size() == 0; n++) @(negedge clk);
    if (rq.size() != 0) begin
      {e, f, s} = rq.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bus.i_valid = 1'b0; bus.i_op = 3'b000; bus.i_a = '0; bus.i_b = '0; bus.i_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_s !== 32'h0 || bus.o_flags !== 4'h0 || bus.o_cf !== 1'b0 || bus.o_err !== 1'b0)
      $display("FAIL reset_outputs: got v=%b s=%h f=%b cf=%b e=%b want all 0",
               bus.o_valid, bus.o_s, bus.o_flags, bus.o_cf, bus.o_err);
    else passed++;
    checks++;
    if (bus.o_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.o_ready);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_wrap();
    logic [31:0] s; logic [3:0] f; logic e; bit ok;
    rq.delete();
    send(3'b000, 32'hFFFF_FFFF, 32'h0000_0001);
    bus.i_valid = 1'b0;
    checks++;
    if (bus.o_valid !== 1'b0) $display("FAIL latency_cycle1: o_valid=%b want 0", bus.o_valid);
    else passed++;
    @(negedge clk);
    checks++;
    if (bus.o_valid !== 1'b1) $display("FAIL latency_cycle2: o_valid=%b want 1", bus.o_valid);
    else passed++;
    get_result(s, f, e, ok);
    checks++;
    if (!ok || s !== 32'h0 || f !== 4'b0110 || e !== 1'b0)
      $display("FAIL add_wrap: got ok=%b s=%h f=%b e=%b want s=00000000 f=0110 e=0", ok, s, f, e);
    else passed++;
    checks++;
    if (bus.o_cf !== 1'b1) $display("FAIL add_wrap_cf: got %b want 1", bus.o_cf);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  op[4] = '{3'b000, 3'b001, 3'b010, 3'b011};
    logic [31:0] a[4]  = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
    logic [31:0] b[4]  = '{32'h1, 32'h0, 32'h1, 32'h0};
    logic [31:0] es[4] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [3:0]  ef[4] = '{4'b0110, 4'b0000, 4'b1000, 4'b1000};
    logic [31:0] s; logic [3:0] f; logic e; bit ok;
    rq.delete();
    for (int i = 0; i < 4; i++) send(op[i], a[i], b[i]);
    bus.i_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      get_result(s, f, e, ok);
      checks++;
      if (!ok || s !== es[i] || f !== ef[i] || e !== 1'b0)
        $display("FAIL chain_%0d: got ok=%b s=%h f=%b e=%b want s=%h f=%b e=0", i, ok, s, f, e, es[i], ef[i]);
      else passed++;
    end
    checks++;
    if (bus.o_cf !== 1'b0) $display("FAIL chain_final_cf: got %b want 0", bus.o_cf);
    else passed++;
  endtask

  task automatic test_overflow_cmp();
    logic [2:0]  op[3] = '{3'b000, 3'b100, 3'b100};
    logic [31:0] a[3]  = '{32'h7FFF_FFFF, 32'h5, 32'h3};
    logic [31:0] b[3]  = '{32'h1, 32'h5, 32'h5};
    logic [31:0] es[3] = '{32'h8000_0000, 32'h0, 32'h0};
    logic [3:0]  ef[3] = '{4'b1001, 4'b0110, 4'b1000};
    logic [31:0] s; logic [3:0] f; logic e; bit ok;
    rq.delete();
    for (int i = 0; i < 3; i++) send(op[i], a[i], b[i]);
    bus.i_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      get_result(s, f, e, ok);
      checks++;
      if (!ok || s !== es[i] || f !== ef[i] || e !== 1'b0)
        $display("FAIL ovf_cmp_%0d: got ok=%b s=%h f=%b e=%b want s=%h f=%b e=0", i, ok, s, f, e, es[i], ef[i]);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a[4]  = '{32'd1, 32'd2, 32'd10, 32'd100};
    logic [31:0] b[4]  = '{32'd1, 32'd3, 32'd20, 32'd200};
    logic [31:0] es[4] = '{32'd2, 32'd5, 32'd30, 32'd300};
    logic [31:0] s; logic [3:0] f; logic e; bit ok;
    int idx;
    bit hold_ok;
    rq.delete();
    bus.i_ready = 1'b0;
    idx = 0;
    hold_ok = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      bus.i_valid = 1'b1; bus.i_op = 3'b000; bus.i_a = a[idx]; bus.i_b = b[idx];
      #1;
      if (cyc >= 2 && (bus.o_valid !== 1'b1 || bus.o_s !== 32'd2)) hold_ok = 1'b0;
      if (bus.o_ready) idx++;
      @(negedge clk);
    end
    checks++;
    if (idx != 2) $display("FAIL bp_accepts: got %0d want 2", idx);
    else passed++;
    checks++;
    if (!hold_ok) $display("FAIL bp_hold: output not held at s=00000002 (now v=%b s=%h)", bus.o_valid, bus.o_s);
    else passed++;
    #1;
    checks++;
    if (bus.o_ready !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", bus.o_ready);
    else passed++;
    @(negedge clk);
    bus.i_ready = 1'b1;
    while (idx < 4) begin
      send(3'b000, a[idx], b[idx]);
      idx++;
    end
    bus.i_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      get_result(s, f, e, ok);
      checks++;
      if (!ok || s !== es[i] || f !== 4'b0000 || e !== 1'b0)
        $display("FAIL bp_order_%0d: got ok=%b s=%h f=%b e=%b want s=%h f=0000 e=0", i, ok, s, f, e, es[i]);
      else passed++;
    end
    repeat (5) @(negedge clk);
    checks++;
    if (rq.size() != 0) $display("FAIL bp_no_dup: got %0d extra results want 0", rq.size());
    else passed++;
  endtask

  task automatic test_clc();
    logic [2:0]  op[3] = '{3'b000, 3'b101, 3'b001};
    logic [31:0] a[3]  = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h0};
    logic [31:0] b[3]  = '{32'h1, 32'h1, 32'h0};
    logic [3:0]  ef[3] = '{4'b0110, 4'b0000, 4'b0100};
    logic [31:0] s; logic [3:0] f; logic e; bit ok;
    rq.delete();
    for (int i = 0; i < 3; i++) send(op[i], a[i], b[i]);
    bus.i_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      get_result(s, f, e, ok);
      checks++;
      if (!ok || s !== 32'h0 || f !== ef[i] || e !== 1'b0)
        $display("FAIL clc_%0d: got ok=%b s=%h f=%b e=%b want s=00000000 f=%b e=0", i, ok, s, f, e, ef[i]);
      else passed++;
    end
    checks++;
    if (bus.o_cf !== 1'b0) $display("FAIL clc_cf: got %b want 0", bus.o_cf);
    else passed++;
  endtask

  task automatic test_opt_ops();
    logic [31:0] s; logic [3:0] f; logic e; bit ok;
    rq.delete();
    send(3'b000, 32'hFFFF_FFFF, 32'h1);
    bus.i_valid = 1'b0;
    get_result(s, f, e, ok);
`ifdef KSA_ALU_SAT_EN
    send(3'b110, 32'h7FFF_FFFF, 32'h10);
    send(3'b111, 32'h8000_0000, 32'h1);
    bus.i_valid = 1'b0;
    get_result(s, f, e, ok);
    checks++;
    if (!ok || s !== 32'h7FFF_FFFF || f !== 4'b0001 || e !== 1'b0)
      $display("FAIL adds_sat: got ok=%b s=%h f=%b e=%b want s=7fffffff f=0001 e=0", ok, s, f, e);
    else passed++;
    get_result(s, f, e, ok);
    checks++;
    if (!ok || s !== 32'h8000_0000 || f !== 4'b1011 || e !== 1'b0)
      $display("FAIL subs_sat: got ok=%b s=%h f=%b e=%b want s=80000000 f=1011 e=0", ok, s, f, e);
    else passed++;
    checks++;
    if (bus.o_sat !== 1'b1 || bus.o_cf !== 1'b1)
      $display("FAIL sat_sticky: got sat=%b cf=%b want sat=1 cf=1", bus.o_sat, bus.o_cf);
    else passed++;
    send(3'b101, 32'h0, 32'h0);
    bus.i_valid = 1'b0;
    get_result(s, f, e, ok);
    checks++;
    if (bus.o_sat !== 1'b0) $display("FAIL sat_clc: got %b want 0", bus.o_sat);
    else passed++;
`else
    send(3'b110, 32'h5, 32'h6);
    send(3'b111, 32'h7, 32'h8);
    bus.i_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      get_result(s, f, e, ok);
      checks++;
      if (!ok || s !== 32'h0 || f !== 4'b0000 || e !== 1'b1)
        $display("FAIL illegal_%0d: got ok=%b s=%h f=%b e=%b want s=00000000 f=0000 e=1", i, ok, s, f, e);
      else passed++;
    end
    checks++;
    if (bus.o_cf !== 1'b1) $display("FAIL illegal_cf: got %b want 1", bus.o_cf);
    else passed++;
`endif
  endtask

  task automatic test_reset_midstream();
    rq.delete();
    bus.i_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(3'b000, 32'hFFFF_FFFF, 32'h1);
    bus.i_valid = 1'b0;
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_cf !== 1'b1)
      $display("FAIL mid_prereset: got v=%b cf=%b want v=1 cf=1", bus.o_valid, bus.o_cf);
    else passed++;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_cf !== 1'b0)
      $display("FAIL mid_async_reset: got v=%b cf=%b want v=0 cf=0", bus.o_valid, bus.o_cf);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    rq.delete();
    repeat (6) @(negedge clk);
    checks++;
    if (rq.size() != 0 || bus.o_valid !== 1'b0)
      $display("FAIL mid_no_stale: got %0d results v=%b want 0 results v=0", rq.size(), bus.o_valid);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_back_to_back();
    test_overflow_cmp();
    test_backpressure();
    test_clc();
    test_opt_ops();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ksa_alu_pipe.md
Name: ksa_alu_pipe

Overview:
- Two-stage pipelined add/subtract unit that wraps the 32-bit Kogge-Stone adder core (ksa_top).
- Registers operands and opcode, conditions operand B and carry-in per opcode, and drives the adder.
- Registers the sum and NZCV flags, and holds a carry flag register so ADC/SBC can chain multi-word arithmetic.
- Sits between the issue logic and writeback, with valid/ready handshakes on both sides.

Parameters:
- W, 32, datapath width; fixed to 32 because the adder core is 32-bit. Any other value is a synthesis-time error.

Ports:
- i_clk  input  1  clock, all state on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  upstream request valid
- o_ready  output  1  stage 1 can accept
- i_op  input  3  000 ADD, 001 ADC, 010 SUB, 011 SBC, 100 CMP, 101 CLC, 110/111 see Optional Feature
- i_a  input  32  operand A
- i_b  input  32  operand B
- o_valid  output  1  stage 2 result valid
- i_ready  input  1  downstream accepts
- o_s  output  32  result
- o_flags  output  4  {N,Z,C,V} of this result
- o_cf  output  1  current carry flag register
- o_err  output  1  result came from an illegal opcode

Behaviour:
- Reset (async, i_rst_n=0): s1_valid=0, s2_valid=0, o_valid=0, o_s=0, o_flags=0, o_cf=0, o_err=0. Releasing reset does not replay anything. Any in-flight op is discarded.
- Handshakes:
  - Accept when i_valid && o_ready.
  - s2 advance = s1_valid && (!s2_valid || i_ready).
  - o_ready = !s1_valid || s2 advance (combinational on i_ready).
  - Output is consumed when o_valid && i_ready.
  - o_s, o_flags and o_err stay stable while o_valid && !i_ready.
- Latency: 2 cycles from accept to o_valid. Throughput: 1 op/cycle with no stalls.
- Adder drive, from stage 1 registers:
  - ADD: b' = B, c0 = 0.
  - ADC: b' = B, c0 = CF.
  - SUB and CMP: b' = ~B, c0 = 1.
  - SBC: b' = ~B, c0 = CF. Borrow convention: C=1 means no borrow.
- Flags:
  - N = s[31].
  - Z = (s == 0).
  - C = adder carry-out.
  - V = (a[31] == b'[31]) && (s[31] != a[31]).
- CMP: o_s = 0, flags computed from the subtraction.
- CLC: o_s = 0, o_flags = {0,0,0,0}, CF cleared.
- CF register:
  - Written on s2 advance for ADD, ADC, SUB, SBC, CMP and CLC.
  - Holds its value otherwise.
  - CF is read in stage 1 only after the preceding op has advanced, so back-to-back ADC/SBC chains need no forwarding.
- Illegal opcode: o_s = 0, o_flags = 0, o_err = 1, CF unchanged.
- Simultaneous accept and s2 advance: both happen in the same cycle. The new op overwrites stage 1.
- Backpressure: s2 full and !i_ready means stage 1 holds, and o_ready drops only if s1_valid.
- Wrap-around: ADD 0xFFFFFFFF + 1 gives s = 0, C = 1, Z = 1. No exceptions are raised.

Optional Feature:
- Macro: KSA_ALU_SAT_EN.
- Defined:
  - 110 = ADDS: signed saturating add, b' = B, c0 = 0.
  - 111 = SUBS: signed saturating subtract, b' = ~B, c0 = 1.
  - If V = 1, o_s clamps to 0x7FFFFFFF when a[31] = 0, or to 0x80000000 when a[31] = 1.
  - o_flags report N/Z of the clamped value, with C and V from the raw adder result.
  - CF is written.
  - Adds output o_sat (1 bit): sticky, set by any saturation, cleared only by reset or CLC.
- Not defined: 110/111 are illegal (o_err = 1), and the o_sat port does not exist.

Test Plan:
- Reset mid-stream: 3 ops in flight, then assert i_rst_n = 0 → o_valid = 0, o_cf = 0 immediately. After release, no stale output appears.
- ADD 0xFFFFFFFF + 0x00000001 → o_s = 0, flags {0,1,1,0}, o_cf = 1, with o_valid exactly 2 cycles after accept.
- 64-bit chain, back-to-back: ADD 0xFFFFFFFF + 1, then ADC 0x00000000 + 0x00000000 → second o_s = 0x00000001. SUB 0 − 1 then SBC 0 − 0 → 0xFFFFFFFF, 0xFFFFFFFF, final C = 0.
- Overflow and compare:
  - ADD 0x7FFFFFFF + 1 → o_s = 0x80000000, V = 1, N = 1.
  - CMP 5, 5 → o_s = 0, Z = 1, C = 1.
  - CMP 3, 5 → N = 1, C = 0.
- Backpressure: stream 4 ADDs with i_ready held 0 for 5 cycles → o_ready falls after 2 accepts. Output holds the first result unchanged. After release, all 4 results arrive in order, none lost or duplicated. CLC mid-stream clears o_cf.
- With KSA_ALU_SAT_EN: ADDS 0x7FFFFFFF + 0x10 → 0x7FFFFFFF, o_sat = 1. SUBS 0x80000000 − 1 → 0x80000000. Without the macro, op 110 → o_err = 1, o_s = 0, CF unchanged.
